// File: rtl/mvtr_pkg.sv
// Shared types and helpers for the TMR voter scrub controller.
package mvtr_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, SCAN, REQ, DONE} scrub_state_t;

  // Index width that stays at least one bit even for a single-entry bank.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvtr_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module mvtr_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mvtr_scrub_ctrl.sv
// Sweeps latched voter warnings and issues refresh write-backs via req/ack,
// keeping a saturating per-voter error count for slow-control readout.
module mvtr_scrub_ctrl
  import mvtr_pkg::*;
#(
  parameter  int NV     = 8,
  parameter  int CNT_W  = 16,
  parameter  int PERIOD = 1024,
  localparam int IW     = idx_w(NV)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             force_i,
  input  logic [NV-1:0]    warn_i,
  output logic             scrub_req_o,
  output logic [IW-1:0]    scrub_idx_o,
  input  logic             scrub_ack_i,
  output logic             busy_o,
  output logic [NV-1:0]    pend_o,
  input  logic [IW-1:0]    rd_sel_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             clr_cnt_i,
  output logic             err_any_o
);

  localparam int            TW    = $clog2(PERIOD);
  localparam int            NPAD  = 1 << IW;
  localparam logic [IW-1:0] LAST  = IW'(NV - 1);
  localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);

  scrub_state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [NV-1:0] pend;
  logic [NV-1:0] inc;
  logic          done;

  // Padded to a power of two so rd_sel_i never indexes past the array.
  logic [NPAD-1:0][CNT_W-1:0] cnt;

  assign done = (state == REQ) && scrub_ack_i;

  for (genvar k = 0; k < NPAD; k++) begin : g_cnt
    if (k < NV) begin : g_live
      assign inc[k] = done && (idx == IW'(k));
      mvtr_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .inc   (inc[k]),
        .clr   (clr_cnt_i),
        .cnt   (cnt[k])
      );
    end else begin : g_pad
      assign cnt[k] = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = '0;
    case (state)
      IDLE: begin
        if (force_i) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end else if (en_i) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (force_i || (en_i && (timer == TLAST))) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end else if (!en_i) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      SCAN: begin
        if (pend[idx])          state_nxt = REQ;
        else if (idx == LAST)   state_nxt = DONE;
        else                    idx_nxt   = idx + IW'(1);
      end
      REQ: begin
        if (scrub_ack_i) begin
          if (idx == LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx + IW'(1);
          end
        end
      end
      DONE:    state_nxt = en_i ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      idx       <= '0;
      timer     <= '0;
      pend      <= '0;
      err_any_o <= 1'b0;
      rd_cnt_o  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      timer    <= timer_nxt;
      // A warning arriving with its own refresh ack keeps the bit for next sweep.
      pend     <= (pend & ~inc) | warn_i;
      rd_cnt_o <= cnt[rd_sel_i];
      if (clr_cnt_i)  err_any_o <= 1'b0;
      else if (done)  err_any_o <= 1'b1;
    end
  end

  assign scrub_req_o = (state == REQ);
  assign scrub_idx_o = scrub_req_o ? idx : '0;
  assign busy_o      = (state == SCAN) || (state == REQ) || (state == DONE);
  assign pend_o      = pend;

endmodule

// File: tb/tb_mvtr_scrub_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// sweep-position reference model, compared on every falling edge.
module tb_mvtr_scrub_ctrl;

  localparam int NV     = 8;
  localparam int CNT_W  = 2;
  localparam int PERIOD = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             force_p = 1'b0;
  logic [NV-1:0]    warn = '0;
  logic             req;
  logic [2:0]       idx;
  logic             ack = 1'b0;
  logic             busy;
  logic [NV-1:0]    pend;
  logic [2:0]       rd_sel = '0;
  logic [CNT_W-1:0] rd_cnt;
  logic             clr = 1'b0;
  logic             err_any;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  mvtr_scrub_ctrl #(.NV(NV), .CNT_W(CNT_W), .PERIOD(PERIOD)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .force_i     (force_p),
    .warn_i      (warn),
    .scrub_req_o (req),
    .scrub_idx_o (idx),
    .scrub_ack_i (ack),
    .busy_o      (busy),
    .pend_o      (pend),
    .rd_sel_i    (rd_sel),
    .rd_cnt_o    (rd_cnt),
    .clr_cnt_i   (clr),
    .err_any_o   (err_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  // Sweep tracked as a position 0..NV (NV = closing cycle) plus a
  // gap counter between sweeps (-1 = not waiting at all).
  bit [NV-1:0] m_pend;
  int          m_cnt[NV];
  bit          m_err;
  int          m_rd;
  bit          m_busy, m_req;
  int          m_pos, m_gap;

  task automatic m_start();
    m_busy = 1'b1;
    m_pos  = 0;
    m_req  = 1'b0;
    m_gap  = -1;
  endtask

  task automatic model_step();
    bit hit;
    int k;
    if (!rst_n) begin
      m_pend = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_rd = 0; m_busy = 0; m_req = 0; m_pos = 0; m_gap = -1;
      return;
    end
    hit  = m_req && ack;
    k    = m_pos;
    m_rd = m_cnt[rd_sel];
    if (clr) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0;
    end else if (hit) begin
      if (m_cnt[k] < CMAX) m_cnt[k]++;
      m_err = 1;
    end
    if (!m_busy) begin
      if (m_gap < 0) begin
        if (force_p) m_start();
        else if (en) m_gap = 0;
      end else begin
        if (force_p)                 m_start();
        else if (!en)                m_gap = -1;
        else if (m_gap == PERIOD-1)  m_start();
        else                         m_gap++;
      end
    end else if (m_pos == NV) begin
      m_busy = 0;
      m_gap  = en ? 0 : -1;
    end else if (m_req) begin
      if (ack) begin m_req = 0; m_pos++; end
    end else if (m_pend[m_pos]) begin
      m_req = 1;
    end else begin
      m_pos++;
    end
    if (hit) m_pend[k] = 1'b0;
    m_pend |= warn;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",    busy,    m_busy);
      chk("req",     req,     m_req);
      chk("idx",     idx,     m_req ? m_pos : 0);
      chk("pend",    pend,    m_pend);
      chk("rd_cnt",  rd_cnt,  m_rd);
      chk("err_any", err_any, m_err);
    end
  end

  // ---------------- ack responder ----------------
  int  ack_dly = 0;
  bit  rnd_ack = 1'b0;
  int  wcnt = 0;
  int  cur_dly = 0;

  always begin
    @(posedge clk); #1;
    if (req === 1'b1) begin
      if (wcnt == 0) cur_dly = rnd_ack ? int'($urandom_range(0, 3)) : ack_dly;
      ack  = (wcnt >= cur_dly);
      wcnt = ack ? 0 : wcnt + 1;
    end else begin
      ack  = 1'b0;
      wcnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int idxq[$];
  int pendq[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) timeout(nm);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!req && n < 100) begin tick(); n++; end
    if (!req) timeout(nm);
  endtask

  task automatic pulse_warn(input logic [NV-1:0] w);
    warn = w; tick(); warn = '0;
  endtask

  task automatic pulse_force();
    force_p = 1'b1; tick(); force_p = 1'b0;
  endtask

  // Runs an in-progress sweep to completion, logging request indices and
  // the pending vector seen right after each request drops.
  task automatic sweep_log(input string nm);
    bit preq = 1'b0;
    int n = 0;
    idxq.delete();
    pendq.delete();
    while (busy && n < 200) begin
      tick(); n++;
      if (req && !preq) idxq.push_back(int'(idx));
      if (!req && preq) pendq.push_back(int'(pend));
      preq = req;
    end
    if (busy) timeout(nm);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nz, first, second, run, runlen, reqs, got;
    bit prevb, stable;

    // Reset and quiet idle
    tick(); chk_on = 1'b1; tick(); tick();
    rst_n = 1'b1;
    nz = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy || req || (|pend) || err_any || (|rd_cnt) || (|idx)) nz++;
    end
    chk("idle_quiet", nz, 0);

    // Periodic sweeps with nothing pending
    en = 1'b1;
    first = -1; second = -1; run = 0; runlen = -1; reqs = 0; prevb = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (req) reqs++;
      if (busy && !prevb) begin
        if (first < 0) first = c; else if (second < 0) second = c;
      end
      if (busy) run++;
      else begin
        if (prevb && runlen < 0) runlen = run;
        run = 0;
      end
      prevb = busy;
    end
    chk("sweep_len", runlen, 9);
    chk("sweep_period", second - first, 25);
    chk("no_req", reqs, 0);
    en = 1'b0;
    wait_idle("en_off_idle");
    tick(); tick();

    // Two warnings, forced sweep
    ack_dly = 1;
    pulse_warn(8'h24);
    chk("pend_latched", pend, 8'h24);
    pulse_force();
    sweep_log("sweep_24");
    got = (idxq.size() == 2) ? (idxq[0] * 16 + idxq[1]) : -1;
    chk("req_order", got, 'h25);
    got = (pendq.size() == 2) ? (pendq[0] * 256 + pendq[1]) : -1;
    chk("pend_trace", got, 'h2000);
    rd_sel = 3'd2; tick();
    chk("cnt2", rd_cnt, 1);
    rd_sel = 3'd5; tick();
    chk("cnt5", rd_cnt, 1);
    chk("model_cnt5", m_cnt[5], 1);
    rd_sel = 3'd0; tick();
    chk("cnt0", rd_cnt, 0);
    chk("err_any_set", err_any, 1);

    // Delayed ack holds request and index steady
    ack_dly = 5;
    pulse_warn(8'h02);
    pulse_force();
    run = 0; stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req) begin
        run++;
        if (idx != 3'd1) stable = 1'b0;
      end else if (run > 0) break;
    end
    chk("ack_wait_len", run, 6);
    chk("ack_wait_idx", stable, 1);
    wait_idle("delayed_ack");

    // Saturation at CNT_W=2, then clear coinciding with the sixth ack
    ack_dly = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int r = 0; r < 5; r++) begin
      pulse_warn(8'h01);
      pulse_force();
      wait_idle("sat_sweep");
    end
    rd_sel = 3'd0; tick();
    chk("cnt0_sat", rd_cnt, 3);
    pulse_warn(8'h01);
    pulse_force();
    wait_req("sixth_req");
    clr = 1'b1; tick(); clr = 1'b0;
    wait_idle("sixth_sweep");
    tick();
    chk("cnt0_clr_wins", rd_cnt, 0);

    // Warning re-raised in the ack cycle of the same voter
    pulse_warn(8'h08);
    pulse_force();
    wait_req("v3_req");
    chk("v3_idx", idx, 3);
    warn = 8'h08; tick(); warn = '0;
    chk("v3_still_pend", pend[3], 1);
    wait_idle("v3_sweep");
    pulse_force();
    sweep_log("v3_resweep");
    got = (idxq.size() == 1) ? idxq[0] : -1;
    chk("v3_rescrub", got, 3);
    chk("v3_cleared", pend, 0);
    rd_sel = 3'd3; tick();
    chk("cnt3", rd_cnt, 2);

    // Reset while a request is outstanding
    ack_dly = 100;
    pulse_warn(8'h40);
    pulse_force();
    wait_req("v6_req");
    tick(); tick();
    rst_n = 1'b0; tick();
    chk("rst_drops_req", req, 0);
    rst_n = 1'b1; ack_dly = 0;
    rd_sel = 3'd6; tick();
    chk("cnt6_after_rst", rd_cnt, 0);
    chk("busy_after_rst", busy, 0);

    // Random traffic
    rnd_ack = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      force_p = ($urandom_range(0, 29) == 0);
      warn    = ($urandom_range(0, 5) == 0) ? (8'($urandom) & 8'($urandom)) : '0;
      clr     = ($urandom_range(0, 149) == 0);
      rd_sel  = 3'($urandom);
      rst_n   = ($urandom_range(0, 599) != 0);
      tick();
    end
    en = 1'b0; force_p = 1'b0; warn = '0; clr = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 40; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvtr_scrub_ctrl.md
# mvtr_scrub_ctrl

Scrub controller for a bank of NV triple-redundant voted registers. It captures each voter's warning flag, then sweeps the bank periodically or on demand. For every voter with a pending warning it issues a refresh (write-back of the voted value) through a req/ack handshake and keeps a saturating per-voter error count for slow-control readout. It sits between the voter warning outputs and the register-file refresh port of the TMR wrapper.

## Interface
- NV, 8: number of monitored voters, 2..64
- CNT_W, 16: width of each per-voter error counter
- PERIOD, 1024: cycles from end of one sweep to start of the next, ≥ 2
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, synchronous, active-low
- en_i  in  1  enables periodic sweeps
- force_i  in  1  single-cycle pulse; starts a sweep immediately
- warn_i  in  NV  per-voter warning flags, bit k from voter k
- scrub_req_o  out  1  refresh request for voter scrub_idx_o
- scrub_idx_o  out  $clog2(NV)  index of the voter being refreshed
- scrub_ack_i  in  1  refresh done; valid only while scrub_req_o=1
- busy_o  out  1  sweep in progress
- pend_o  out  NV  latched pending-warning vector
- rd_sel_i  in  $clog2(NV)  counter readout select
- rd_cnt_o  out  CNT_W  error counter of voter rd_sel_i, registered
- clr_cnt_i  in  1  clears all counters and err_any_o
- err_any_o  out  1  sticky: set when any counter increments

## Operation
- pend[k] sets on any cycle with warn_i[k]=1 and clears only when the refresh of voter k completes.
- States:
  - IDLE: timer held at 0. Go to WAIT when en_i=1. Go to SCAN (idx=0) on force_i.
  - WAIT: timer increments. At timer==PERIOD-1, or on force_i, go to SCAN with idx=0 and timer=0. If en_i=0, go to IDLE.
  - SCAN: one cycle per index. If pend[idx]=1, go to REQ. Otherwise, at idx==NV-1 go to DONE, else idx+1 and stay in SCAN.
  - REQ: scrub_req_o=1, scrub_idx_o=idx, both stable until scrub_ack_i=1. On ack:
    - clear pend[idx]
    - cnt[idx] += 1, saturating at 2^CNT_W-1
    - set err_any_o
    - go to DONE at idx==NV-1, else idx+1 and go to SCAN
  - DONE: one cycle, then WAIT if en_i=1, else IDLE.
- force_i while busy_o=1 is ignored.
- en_i falling mid-sweep does not abort: the sweep completes, then IDLE.
- A new warn_i[k] in the same cycle as the ack for k: set wins, pend[k] stays 1 and is handled next sweep.
- clr_cnt_i on the same cycle as an increment: clear wins, counter becomes 0.
- rd_cnt_o = cnt[rd_sel_i], registered.

## Timing
- Reset values: all state, timer and counters 0. Every output is 0; state is IDLE.
- warn_i → pend_o: 1 cycle.
- Sweep with no pending bits: NV SCAN cycles + 1 DONE cycle; busy_o=1 throughout.
- Each refreshed voter adds 1 REQ cycle plus the ack wait.
- scrub_req_o deasserts the cycle after ack is sampled. The earliest next req is 2 cycles after that ack (via SCAN). A combinational ack in the first REQ cycle is legal.
- Sweep start to next sweep start, no refreshes: NV+1+PERIOD cycles.
- rd_sel_i → rd_cnt_o: 1 cycle.
- rst_n_i low in any state returns to IDLE on the next edge. An outstanding req is dropped with no refresh counted.

## Structure
- Package mvtr_pkg:
  - enum scrub_state_t {IDLE, WAIT, SCAN, REQ, DONE}
  - function for width of a clog2-safe index (min 1 bit)
- Sub-module mvtr_sat_cnt: CNT_W saturating counter with inc, clr, clear priority. Instantiated NV times.
- The FSM, pending register and timer live in the top.

## Test plan
- Reset, en_i=0, warn_i=0: all outputs 0 for 100 cycles; no sweep until force_i.
- NV=8, PERIOD=16, en_i=1, no warnings: busy_o high for 9 cycles, sweep starts repeat every 25 cycles, scrub_req_o never 1.
- warn_i=8'h24 for one cycle, then force_i:
  - req idx=2, then idx=5
  - pend_o 24→20→00
  - cnt[2]=cnt[5]=1, err_any_o=1
- Ack delayed 5 cycles: scrub_req_o and scrub_idx_o stable for all 5 cycles, deassert 1 cycle after ack.
- CNT_W=2, voter 0 warned and scrubbed 5 times: cnt[0] stays 3. clr_cnt_i together with the 6th ack gives cnt[0]=0.
- warn_i[3] asserted in the ack cycle for voter 3: pend_o[3] stays 1, refreshed again next sweep. rst_n_i low during REQ: req drops next edge, counter unchanged.
